// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_pkg                                                |
// | Description : Shared constants, scan-code values and FSM encoding    |
// |               for the PS/2 set-2 key decoder.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ps2_pkg;

    // Set-2 prefix and modifier scan codes
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_PAUSE  = 8'h77;

    // Bytes left to swallow after the E1 of the 8-byte Pause sequence
    localparam logic [2:0] E1_SKIP   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_E0   = 3'd1,
        ST_PRE_F0   = 3'd2,
        ST_PRE_E0F0 = 3'd3,
        ST_SKIP_E1  = 3'd4,
        ST_EMIT     = 3'd5
    } ps2_state_t;

    // Keyboard status/ack bytes that never form part of a key event
    function automatic logic is_dropped(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_ascii_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_ascii_rom                                          |
// | Description : Combinational set-2 scan code to ASCII translation.    |
// |   code  in 8 : base scan code (prefixes stripped)                    |
// |   ext   in 1 : code carried an E0/E1 prefix                          |
// |   shift in 1 : shift state before this event                         |
// |   caps  in 1 : caps-lock state before this event                     |
// |   ascii out 8: character, 0 for non-printing keys                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_ascii_rom (
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] w_lower;    // nonzero only for letter keys
    logic [7:0] w_plain;
    logic [7:0] w_shifted;

    always_comb begin
        w_lower   = 8'h00;
        w_plain   = 8'h00;
        w_shifted = 8'h00;
        case (code)
            8'h1C: w_lower = 8'h61; 8'h32: w_lower = 8'h62;
            8'h21: w_lower = 8'h63; 8'h23: w_lower = 8'h64;
            8'h24: w_lower = 8'h65; 8'h2B: w_lower = 8'h66;
            8'h34: w_lower = 8'h67; 8'h33: w_lower = 8'h68;
            8'h43: w_lower = 8'h69; 8'h3B: w_lower = 8'h6A;
            8'h42: w_lower = 8'h6B; 8'h4B: w_lower = 8'h6C;
            8'h3A: w_lower = 8'h6D; 8'h31: w_lower = 8'h6E;
            8'h44: w_lower = 8'h6F; 8'h4D: w_lower = 8'h70;
            8'h15: w_lower = 8'h71; 8'h2D: w_lower = 8'h72;
            8'h1B: w_lower = 8'h73; 8'h2C: w_lower = 8'h74;
            8'h3C: w_lower = 8'h75; 8'h2A: w_lower = 8'h76;
            8'h1D: w_lower = 8'h77; 8'h22: w_lower = 8'h78;
            8'h35: w_lower = 8'h79; 8'h1A: w_lower = 8'h7A;
            default: w_lower = 8'h00;
        endcase
        case (code)
            8'h16: begin w_plain = 8'h31; w_shifted = 8'h21; end
            8'h1E: begin w_plain = 8'h32; w_shifted = 8'h40; end
            8'h26: begin w_plain = 8'h33; w_shifted = 8'h23; end
            8'h25: begin w_plain = 8'h34; w_shifted = 8'h24; end
            8'h2E: begin w_plain = 8'h35; w_shifted = 8'h25; end
            8'h36: begin w_plain = 8'h36; w_shifted = 8'h5E; end
            8'h3D: begin w_plain = 8'h37; w_shifted = 8'h26; end
            8'h3E: begin w_plain = 8'h38; w_shifted = 8'h2A; end
            8'h46: begin w_plain = 8'h39; w_shifted = 8'h28; end
            8'h45: begin w_plain = 8'h30; w_shifted = 8'h29; end
            8'h0E: begin w_plain = 8'h60; w_shifted = 8'h7E; end
            8'h4E: begin w_plain = 8'h2D; w_shifted = 8'h5F; end
            8'h55: begin w_plain = 8'h3D; w_shifted = 8'h2B; end
            8'h54: begin w_plain = 8'h5B; w_shifted = 8'h7B; end
            8'h5B: begin w_plain = 8'h5D; w_shifted = 8'h7D; end
            8'h5D: begin w_plain = 8'h5C; w_shifted = 8'h7C; end
            8'h4C: begin w_plain = 8'h3B; w_shifted = 8'h3A; end
            8'h52: begin w_plain = 8'h27; w_shifted = 8'h22; end
            8'h41: begin w_plain = 8'h2C; w_shifted = 8'h3C; end
            8'h49: begin w_plain = 8'h2E; w_shifted = 8'h3E; end
            8'h4A: begin w_plain = 8'h2F; w_shifted = 8'h3F; end
            // Control keys translate identically with or without shift
            8'h5A: begin w_plain = 8'h0D; w_shifted = 8'h0D; end
            8'h66: begin w_plain = 8'h08; w_shifted = 8'h08; end
            8'h29: begin w_plain = 8'h20; w_shifted = 8'h20; end
            8'h0D: begin w_plain = 8'h09; w_shifted = 8'h09; end
            8'h76: begin w_plain = 8'h1B; w_shifted = 8'h1B; end
            default: begin w_plain = 8'h00; w_shifted = 8'h00; end
        endcase

        if (ext) begin
            // Only keypad '/' and keypad Enter print among extended keys
            if (code == 8'h4A)      ascii = 8'h2F;
            else if (code == 8'h5A) ascii = 8'h0D;
            else                    ascii = 8'h00;
        end else if (w_lower != 8'h00) begin
            ascii = (shift ^ caps) ? (w_lower - 8'h20) : w_lower;
        end else begin
            ascii = shift ? w_shifted : w_plain;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_key_decoder                                        |
// | Description : Folds PS/2 set-2 byte sequences into key events on a   |
// |               valid/ready port and tracks modifier/caps state.       |
// |   kbd_data/kbd_ready in, kbd_read out : receiver FIFO pop side       |
// |   key_valid out, key_ready in          : event handshake             |
// |   key_code/ext/break/ascii out         : event fields                |
// |   mod_shift/ctrl/alt, caps_lock out    : current modifier state      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter bit ASCII_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       kbd_read,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [7:0] key_ascii,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       caps_lock
);

    ps2_state_t r_state;
    ps2_state_t w_next;
    logic [2:0] r_skip_cnt, w_skip_next;
    logic       r_rd_d;
    logic       r_key_valid, r_key_ext, r_key_break;
    logic [7:0] r_key_code, r_key_ascii;
    logic       r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
    logic       r_caps, r_caps_held;

    logic       w_rd, w_emit, w_ev_ext, w_ev_brk, w_shift;
    logic [7:0] w_ev_code, w_ascii;

    // The receiver lowers ready a cycle after a pop, so r_rd_d keeps us
    // from double-popping on a stale ready.
    assign w_rd    = kbd_ready && (r_state != ST_EMIT) && !r_rd_d && !rst;
    assign w_shift = r_lshift | r_rshift;

    // Next-state and event decode for the byte currently at the FIFO head
    always_comb begin
        w_next      = r_state;
        w_skip_next = r_skip_cnt;
        w_emit      = 1'b0;
        w_ev_code   = kbd_data;
        w_ev_ext    = 1'b0;
        w_ev_brk    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (kbd_data == SC_E0)      w_next = ST_PRE_E0;
                else if (kbd_data == SC_F0) w_next = ST_PRE_F0;
                else if (kbd_data == SC_E1) begin
                    w_next      = ST_SKIP_E1;
                    w_skip_next = E1_SKIP;
                end else if (!is_dropped(kbd_data)) w_emit = 1'b1;
            end
            ST_PRE_E0: begin
                if (kbd_data == SC_F0)          w_next = ST_PRE_E0F0;
                else if (kbd_data == SC_LSHIFT) w_next = ST_IDLE;   // fake shift
                else begin
                    w_emit   = 1'b1;
                    w_ev_ext = 1'b1;
                end
            end
            ST_PRE_F0: begin
                w_emit   = 1'b1;
                w_ev_brk = 1'b1;
            end
            ST_PRE_E0F0: begin
                if (kbd_data == SC_LSHIFT) w_next = ST_IDLE;
                else begin
                    w_emit   = 1'b1;
                    w_ev_ext = 1'b1;
                    w_ev_brk = 1'b1;
                end
            end
            ST_SKIP_E1: begin
                if (r_skip_cnt <= 3'd1) begin
                    w_skip_next = 3'd0;
                    w_emit      = 1'b1;
                    w_ev_code   = SC_PAUSE;
                    w_ev_ext    = 1'b1;
                end else begin
                    w_skip_next = r_skip_cnt - 3'd1;
                end
            end
            default: w_next = r_state;
        endcase
        if (w_emit) w_next = ST_EMIT;
    end

    // ASCII is looked up with pre-update modifier state, so a break reports
    // the same character as its make.
    generate
        if (ASCII_EN) begin : g_ascii_rom
            ps2_ascii_rom u_ascii_rom (
                .code  (w_ev_code),
                .ext   (w_ev_ext),
                .shift (w_shift),
                .caps  (r_caps),
                .ascii (w_ascii)
            );
        end else begin : g_no_ascii
            assign w_ascii = 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_skip_cnt  <= 3'd0;
            r_rd_d      <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_break <= 1'b0;
            r_key_ascii <= 8'h00;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_lalt      <= 1'b0;
            r_ralt      <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else begin
            r_rd_d <= w_rd;
            if (r_state == ST_EMIT) begin
                if (key_ready) begin
                    r_key_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            end else if (w_rd) begin
                r_state    <= w_next;
                r_skip_cnt <= w_skip_next;
                if (w_emit) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= w_ev_code;
                    r_key_ext   <= w_ev_ext;
                    r_key_break <= w_ev_brk;
                    r_key_ascii <= w_ascii;
                    if (!w_ev_ext) begin
                        case (w_ev_code)
                            SC_LSHIFT: r_lshift <= !w_ev_brk;
                            SC_RSHIFT: r_rshift <= !w_ev_brk;
                            SC_CTRL:   r_lctrl  <= !w_ev_brk;
                            SC_ALT:    r_lalt   <= !w_ev_brk;
                            SC_CAPS: begin
                                // Typematic repeats arrive with caps_held set
                                // and must not toggle again.
                                if (w_ev_brk) begin
                                    r_caps_held <= 1'b0;
                                end else begin
                                    if (!r_caps_held) r_caps <= !r_caps;
                                    r_caps_held <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        case (w_ev_code)
                            SC_CTRL: r_rctrl <= !w_ev_brk;
                            SC_ALT:  r_ralt  <= !w_ev_brk;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign kbd_read  = w_rd;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_ext   = r_key_ext;
    assign key_break = r_key_break;
    assign key_ascii = r_key_ascii;
    assign mod_shift = w_shift;
    assign mod_ctrl  = r_lctrl | r_rctrl;
    assign mod_alt   = r_lalt | r_ralt;
    assign caps_lock = r_caps;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ps2_key_decoder                                     |
// | Description : Directed self-checking bench for ps2_key_decoder with  |
// |               a simple receiver FIFO model and event log.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_read;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] key_ascii;
    logic       mod_shift, mod_ctrl, mod_alt, caps_lock;

    always #5 clk = ~clk;

    ps2_key_decoder #(.ASCII_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .kbd_read  (kbd_read),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_break (key_break),
        .key_ascii (key_ascii),
        .mod_shift (mod_shift),
        .mod_ctrl  (mod_ctrl),
        .mod_alt   (mod_alt),
        .caps_lock (caps_lock)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
        logic       shift;
        logic       caps;
    } ev_t;

    logic [7:0] q[$];       // bytes ever queued; head marks the FIFO front
    int         head = 0;
    logic       pop_pending = 1'b0;
    int         n_pops = 0;
    ev_t        ev[$];
    int         n_checks = 0;
    int         n_pass = 0;

    // Monitor: pops and accepted events, sampled mid-cycle
    always @(negedge clk) begin
        pop_pending = kbd_read;
        if (kbd_read) n_pops++;
        if (key_valid && key_ready)
            ev.push_back('{key_code, key_ext, key_break, key_ascii, mod_shift, caps_lock});
    end

    // Receiver FIFO model
    always @(posedge clk) begin
        #1;
        if (pop_pending) head++;
        kbd_ready = (head < q.size());
        kbd_data  = kbd_ready ? q[head] : 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (((head < q.size()) || key_valid) && i < 400) begin
            tick();
            i++;
        end
        repeat (4) tick();
        n_checks++;
        if (i >= 400) $display("FAIL %s_drain: timed out with %0d bytes left", name, q.size() - head);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if ({key_valid, key_ext, key_break, kbd_read} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {key_valid, key_ext, key_break, kbd_read});
        else n_pass++;
        n_checks++;
        if ({key_code, key_ascii} !== 16'h0000)
            $display("FAIL reset_fields: got %h want 0000", {key_code, key_ascii});
        else n_pass++;
        n_checks++;
        if ({mod_shift, mod_ctrl, mod_alt, caps_lock} !== 4'b0000)
            $display("FAIL reset_mods: got %b want 0000", {mod_shift, mod_ctrl, mod_alt, caps_lock});
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_make();
        int b, p;
        b = ev.size();
        p = n_pops;
        push(8'h1C);
        drain("single");
        n_checks++;
        if (ev.size() - b !== 1) $display("FAIL single_count: got %0d want 1", ev.size() - b);
        else n_pass++;
        n_checks++;
        if (n_pops - p !== 1) $display("FAIL single_pops: got %0d want 1", n_pops - p);
        else n_pass++;
        if (ev.size() > b) begin
            n_checks++;
            if ({ev[b].code, ev[b].ext, ev[b].brk, ev[b].ascii} !== {8'h1C, 1'b0, 1'b0, 8'h61})
                $display("FAIL single_event: got %h/%b/%b/%h want 1c/0/0/61",
                         ev[b].code, ev[b].ext, ev[b].brk, ev[b].ascii);
            else n_pass++;
        end
    endtask

    task automatic test_shift();
        int b;
        b = ev.size();
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
        drain("shift");
        n_checks++;
        if (ev.size() - b !== 4) $display("FAIL shift_count: got %0d want 4", ev.size() - b);
        else n_pass++;
        if (ev.size() - b == 4) begin
            n_checks++;
            if ({ev[b+1].code, ev[b+1].brk, ev[b+1].ascii, ev[b+1].shift} !== {8'h1C, 1'b0, 8'h41, 1'b1})
                $display("FAIL shift_make: got %h/%b/%h/%b want 1c/0/41/1",
                         ev[b+1].code, ev[b+1].brk, ev[b+1].ascii, ev[b+1].shift);
            else n_pass++;
            n_checks++;
            if ({ev[b+2].code, ev[b+2].brk, ev[b+2].ascii} !== {8'h1C, 1'b1, 8'h41})
                $display("FAIL shift_break: got %h/%b/%h want 1c/1/41",
                         ev[b+2].code, ev[b+2].brk, ev[b+2].ascii);
            else n_pass++;
            n_checks++;
            if ({ev[b].shift, ev[b].ascii, ev[b+3].brk, ev[b+3].shift} !== {1'b1, 8'h00, 1'b1, 1'b0})
                $display("FAIL shift_mod_events: got %b/%h/%b/%b want 1/00/1/0",
                         ev[b].shift, ev[b].ascii, ev[b+3].brk, ev[b+3].shift);
            else n_pass++;
        end
        n_checks++;
        if (mod_shift !== 1'b0) $display("FAIL shift_final: got %b want 0", mod_shift);
        else n_pass++;
    endtask

    task automatic test_ext_break();
        int b;
        b = ev.size();
        push(8'hE0); push(8'hF0); push(8'h75);
        drain("extbrk");
        n_checks++;
        if (ev.size() - b !== 1) $display("FAIL extbrk_count: got %0d want 1", ev.size() - b);
        else n_pass++;
        if (ev.size() > b) begin
            n_checks++;
            if ({ev[b].code, ev[b].ext, ev[b].brk, ev[b].ascii} !== {8'h75, 1'b1, 1'b1, 8'h00})
                $display("FAIL extbrk_event: got %h/%b/%b/%h want 75/1/1/00",
                         ev[b].code, ev[b].ext, ev[b].brk, ev[b].ascii);
            else n_pass++;
        end
    endtask

    task automatic test_caps();
        int b;
        b = ev.size();
        push(8'h58); push(8'h58); push(8'hF0); push(8'h58); push(8'h58); push(8'h1C);
        drain("caps");
        n_checks++;
        if (ev.size() - b !== 5) $display("FAIL caps_count: got %0d want 5", ev.size() - b);
        else n_pass++;
        if (ev.size() - b == 5) begin
            n_checks++;
            if ({ev[b].caps, ev[b+1].caps, ev[b+2].caps, ev[b+3].caps} !== 4'b1110)
                $display("FAIL caps_sequence: got %b want 1110",
                         {ev[b].caps, ev[b+1].caps, ev[b+2].caps, ev[b+3].caps});
            else n_pass++;
            n_checks++;
            if (ev[b+4].ascii !== 8'h61) $display("FAIL caps_after: got %h want 61", ev[b+4].ascii);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        int b, p;
        b = ev.size();
        p = n_pops;
        push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
        push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
        push(8'hAA); push(8'hFA);
        drain("pause");
        n_checks++;
        if (ev.size() - b !== 1) $display("FAIL pause_count: got %0d want 1", ev.size() - b);
        else n_pass++;
        if (ev.size() > b) begin
            n_checks++;
            if ({ev[b].code, ev[b].ext, ev[b].brk, ev[b].ascii} !== {8'h77, 1'b1, 1'b0, 8'h00})
                $display("FAIL pause_event: got %h/%b/%b/%h want 77/1/0/00",
                         ev[b].code, ev[b].ext, ev[b].brk, ev[b].ascii);
            else n_pass++;
        end
        n_checks++;
        if (n_pops - p !== 10) $display("FAIL pause_pops: got %0d want 10", n_pops - p);
        else n_pass++;
        n_checks++;
        if (mod_ctrl !== 1'b0) $display("FAIL pause_ctrl: got %b want 0", mod_ctrl);
        else n_pass++;
    endtask

    task automatic test_ascii();
        int b;
        do_reset();
        b = ev.size();
        push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h12);
        push(8'hE0); push(8'h4A); push(8'h16); push(8'h12); push(8'h16);
        drain("ascii");
        n_checks++;
        if (ev.size() - b !== 10) $display("FAIL ascii_count: got %0d want 10", ev.size() - b);
        else n_pass++;
        if (ev.size() - b == 10) begin
            n_checks++;
            if ({ev[b+2].ascii, ev[b+4].ascii} !== {8'h41, 8'h61})
                $display("FAIL ascii_caps_shift: got %h/%h want 41/61", ev[b+2].ascii, ev[b+4].ascii);
            else n_pass++;
            n_checks++;
            if ({ev[b+6].code, ev[b+6].ext, ev[b+6].ascii} !== {8'h4A, 1'b1, 8'h2F})
                $display("FAIL ascii_kp_slash: got %h/%b/%h want 4a/1/2f",
                         ev[b+6].code, ev[b+6].ext, ev[b+6].ascii);
            else n_pass++;
            n_checks++;
            if ({ev[b+7].ascii, ev[b+9].ascii} !== {8'h31, 8'h21})
                $display("FAIL ascii_digit: got %h/%h want 31/21", ev[b+7].ascii, ev[b+9].ascii);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int b, p;
        do_reset();
        b = ev.size();
        p = n_pops;
        key_ready = 1'b0;
        push(8'h1C); push(8'h32); push(8'h21);
        repeat (20) tick();
        n_checks++;
        if ({n_pops - p, q.size() - head} !== {32'd1, 32'd2})
            $display("FAIL bp_pops: got %0d pops %0d queued want 1 pops 2 queued", n_pops - p, q.size() - head);
        else n_pass++;
        n_checks++;
        if ({key_valid, kbd_read, key_code} !== {1'b1, 1'b0, 8'h1C})
            $display("FAIL bp_hold: got %b/%b/%h want 1/0/1c", key_valid, kbd_read, key_code);
        else n_pass++;
        repeat (5) tick();
        n_checks++;
        if ({key_valid, key_code, key_ascii} !== {1'b1, 8'h1C, 8'h61})
            $display("FAIL bp_stable: got %b/%h/%h want 1/1c/61", key_valid, key_code, key_ascii);
        else n_pass++;
        key_ready = 1'b1;
        drain("bp");
        n_checks++;
        if (ev.size() - b !== 3) $display("FAIL bp_count: got %0d want 3", ev.size() - b);
        else n_pass++;
        if (ev.size() - b == 3) begin
            n_checks++;
            if ({ev[b].code, ev[b+1].code, ev[b+2].code, ev[b+2].ascii} !== {8'h1C, 8'h32, 8'h21, 8'h63})
                $display("FAIL bp_order: got %h %h %h/%h want 1c 32 21/63",
                         ev[b].code, ev[b+1].code, ev[b+2].code, ev[b+2].ascii);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int b, i;
        b = ev.size();
        push(8'hE0);
        i = 0;
        while ((head < q.size()) && i < 100) begin
            tick();
            i++;
        end
        n_checks++;
        if (i >= 100) $display("FAIL rstmid_pop: timed out, %0d bytes left", q.size() - head);
        else n_pass++;
        repeat (2) tick();
        do_reset();
        push(8'h1C);
        drain("rstmid");
        n_checks++;
        if (ev.size() - b !== 1) $display("FAIL rstmid_count: got %0d want 1", ev.size() - b);
        else n_pass++;
        if (ev.size() > b) begin
            n_checks++;
            if ({ev[b].code, ev[b].ext, ev[b].ascii} !== {8'h1C, 1'b0, 8'h61})
                $display("FAIL rstmid_event: got %h/%b/%h want 1c/0/61",
                         ev[b].code, ev[b].ext, ev[b].ascii);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_shift();
        test_ext_break();
        test_caps();
        test_pause();
        test_ascii();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes raw scan-code bytes from the PS/2 keyboard receiver FIFO (`data`/`ready`/`read` side) and turns set-2 byte sequences (`E0`, `F0`, `E1` prefixes) into single key events. Each event carries make/break, extended flag, base code, modifier state and an ASCII translation. Events are presented on a valid/ready port to the CPU-side MMIO keyboard register. Modifier and Caps Lock state are tracked internally.

## Interface
- `ASCII_EN`, 1: 0 forces `key_ascii` to 0 and the ROM may be removed.
- `clk`  in  1  system clock; same clock as the receiver.
- `rst`  in  1  synchronous reset, active-high.
- `kbd_data`  in  8  receiver FIFO head byte.
- `kbd_ready`  in  1  FIFO non-empty.
- `kbd_read`  out  1  one-cycle pop strobe to the receiver.
- `key_valid`  out  1  event available; held until accepted.
- `key_ready`  in  1  consumer accepts the event when `key_valid` and `key_ready` are both high.
- `key_code`  out  8  base scan code, with prefixes stripped.
- `key_ext`  out  1  event had an `E0` or `E1` prefix.
- `key_break`  out  1  1 means release, 0 means press.
- `key_ascii`  out  8  translated character; 0 if the key is non-printing.
- `mod_shift`, `mod_ctrl`, `mod_alt`, `caps_lock`  out  1 each  current modifier state.

## Operation
- FSM states:
  - IDLE
  - PRE_E0
  - PRE_F0
  - PRE_E0F0
  - SKIP_E1
  - EMIT
- Byte handling, in IDLE:
  - `E0` goes to PRE_E0.
  - `F0` goes to PRE_F0.
  - `E1` loads `skip_cnt` = 7 and goes to SKIP_E1.
  - `AA`, `FA`, `EE`, `FE`, `00`, `FF` are dropped.
  - Any other byte latches a make event and goes to EMIT.
- Byte handling, in the prefix states:
  - PRE_E0: `F0` goes to PRE_E0F0. `12` (fake shift) is dropped and returns to IDLE. Any other byte emits an extended make.
  - PRE_F0: emits a break event.
  - PRE_E0F0: `12` is dropped and returns to IDLE. Any other byte emits an extended break.
  - SKIP_E1: decrements per byte. At 0, emits `key_code`=`77`, `key_ext`=1, `key_break`=0 (Pause).
- EMIT:
  - Holds `key_valid`=1 and all `key_*` fields stable, and pops nothing.
  - On handshake, returns to IDLE.
- Modifier updates happen on the cycle EMIT is entered:
  - Shift: `12` or `59`.
  - Ctrl: `14` or `E0 14`.
  - Alt: `11` or `E0 11`.
  - Each is set on make and cleared on break; left and right are tracked separately and the outputs OR them.
- Caps Lock (`58`):
  - Toggles on a make only when the internal `caps_held` flag is 0; `caps_held` is set on make and cleared on break. Typematic repeats therefore do not toggle.
- ASCII translation, for non-extended codes:
  - Letters are uppercase when `shift ^ caps`.
  - Digits and punctuation use shift only.
  - `5A` gives `0D`, `66` gives `08`, `29` gives `20`, `0D` gives `09`, `76` gives `1B`.
  - Extended keys: `E0 4A` gives `2F` and `E0 5A` gives `0D`; all other extended keys give 0.
  - The shift/caps state used is the state before this event's own modifier update.
  - Break events carry the same ASCII as the matching make.
- Reset values:
  - FSM to IDLE.
  - `key_valid`=0 and all `key_*` fields 0.
  - All modifiers and `caps_lock`=0.
  - `kbd_read`=0, `skip_cnt`=0.
  - Reset mid-sequence discards any partial prefix.

## Timing
- `kbd_read` = `kbd_ready` & state≠EMIT & `!rd_d`, where `rd_d` is `kbd_read` delayed one cycle.
  - The receiver updates `ready` one cycle after a pop, so strobes are never back-to-back. Peak rate is one byte per 2 cycles.
- The byte is consumed on the same cycle `kbd_read` is high.
- Latency: final byte popped in cycle t gives `key_valid`=1 in cycle t+1 (registered).
- With `key_ready` held high, EMIT lasts 1 cycle and the next pop can occur the same cycle EMIT exits.
- Backpressure: while in EMIT, `kbd_read`=0. Further bytes wait in the receiver FIFO; receiver overflow is its own concern.
- `kbd_ready` low during a prefix: the state is held indefinitely, with no timeout.

## Structure
- Package `ps2_pkg`:
  - Scan-code constants `SC_E0`, `SC_E1`, `SC_F0`, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CTRL`, `SC_ALT`, `SC_CAPS`.
  - The FSM state encoding.
  - `E1_SKIP` = 7.
- Sub-module `ps2_ascii_rom`: combinational, inputs `{code[7:0], ext, shift, caps}`, output ascii[7:0]; instantiated only when `ASCII_EN`.

## Test plan
- `1C` queued, `key_ready`=1 → one event: code `1C`, break 0, ext 0, ascii `61`; `kbd_read` pulses exactly once.
- `12`, `1C`, `F0 1C`, `F0 12` → events `1C`/ascii `41` (make, then break); `mod_shift` is 1 between shift make and shift break.
- `E0 F0 75` → a single event: code `75`, ext 1, break 1, ascii 0; no event for the prefixes.
- `58`, `58`, `F0 58`, `58` → `caps_lock` goes 1, stays 1 on the repeat, then goes 0; a following `1C` gives ascii `61`.
- `E1 14 77 E1 F0 14 F0 77` → exactly one event: code `77`, ext 1; then `AA`, `FA` → no events.
- Hold `key_ready`=0 with 3 bytes queued → `kbd_read` stays 0 and the event is stable; releasing gives in-order events. `rst` pulsed after `E0` → the next `1C` decodes as non-extended.
